// File: rtl/rfphoenix_dcache_rd_pkg.sv
// Shared types and line geometry for the dcache read/refill engine.
package rfPhoenixPkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FETCH,
    FILL
  } dcache_rd_state_t;

  localparam int DC_BEAT_BYTES = 16;
  localparam int DC_LINE_BYTES = 64;

endpackage

// File: rtl/rfphoenix_line_assembler.sv
// Collects refill beats into line slots, starting at the critical beat and wrapping.
module rfphoenix_line_assembler #(
  parameter int BEAT_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(BEATS)-1:0]  start_idx,
  input  logic                      beat_we,
  input  logic [BEAT_W-1:0]         beat_dat,
  output logic [$clog2(BEATS)-1:0]  beat_idx,
  output logic                      last_beat,
  output logic                      complete,
  output logic [BEAT_W*BEATS-1:0]   line
);

  localparam int IDX_W = $clog2(BEATS);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BEATS - 1);

  logic [BEAT_W-1:0] slot [BEATS];
  logic [CNT_W-1:0]  rcvd;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx <= '0;
      rcvd     <= '0;
      complete <= 1'b0;
      for (int i = 0; i < BEATS; i++) slot[i] <= '0;
    end else if (start) begin
      beat_idx <= start_idx;
      rcvd     <= '0;
      complete <= 1'b0;
    end else if (beat_we) begin
      slot[beat_idx] <= beat_dat;
      // BEATS is a power of two, so the index wraps on its own
      beat_idx       <= beat_idx + 1'b1;
      rcvd           <= rcvd + 1'b1;
      complete       <= (rcvd == LAST_C);
    end
  end

  assign last_beat = (rcvd == LAST_C);

  for (genvar g = 0; g < BEATS; g++) begin : g_line
    assign line[g*BEAT_W +: BEAT_W] = slot[g];
  end

  logic [IDX_W-1:0] unused_idx_w;
  assign unused_idx_w = '0;

endmodule

// File: rtl/rfphoenix_dcache_rd.sv
// Load-side dcache engine: tag-hit return, critical-beat-first line refill with
// early restart, single-beat uncached reads, store snoop and bus timeout.
module rfphoenix_dcache_rd
  import rfPhoenixPkg::*;
#(
  parameter int ADR_W  = 32,
  parameter int BEAT_W = DC_BEAT_BYTES * 8,
  parameter int BEATS  = DC_LINE_BYTES / DC_BEAT_BYTES,
  parameter int TMO    = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_v,
  output logic                     req_rdy,
  input  logic [ADR_W-1:0]         req_adr,
  input  logic [3:0]               req_acr,
  input  logic                     hit,
  input  logic [BEAT_W*BEATS-1:0]  dc_dat,
  input  logic                     st_v,
  input  logic [ADR_W-1:0]         st_adr,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic [ADR_W-1:0]         adr_o,
  input  logic                     ack_i,
  input  logic                     err_i,
  input  logic [BEAT_W-1:0]        dat_i,
  output logic                     wr_dc,
  output logic [ADR_W-1:0]         wr_adr,
  output logic [BEAT_W*BEATS-1:0]  wr_line,
  output logic                     resp_v,
  output logic [BEAT_W-1:0]        resp_dat,
  output logic                     resp_err
);

  localparam int BYTE_BITS = $clog2(BEAT_W / 8);
  localparam int IDX_W     = $clog2(BEATS);
  localparam int LINE_LSB  = BYTE_BITS + IDX_W;
  localparam int TMO_W     = $clog2(TMO + 1);
  localparam logic [TMO_W-1:0] TMO_C = TMO_W'(TMO);

  dcache_rd_state_t state, state_nxt;

  logic [ADR_W-1:0]  adr_q;
  logic              cach_q, sent_q, stale_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              accept, snoop_hit;
  logic              asm_start, beat_we, resp_ld, resp_bus;
  logic              resp_v_nxt, resp_err_nxt, tmo_inc, tmo_clr;
  logic [IDX_W-1:0]  crit_idx, beat_idx;
  logic              last_beat, line_done;
  logic [BEAT_W*BEATS-1:0] line;
  logic [BEAT_W-1:0] dc_beat [BEATS];

  for (genvar g = 0; g < BEATS; g++) begin : g_dc_beat
    assign dc_beat[g] = dc_dat[g*BEAT_W +: BEAT_W];
  end

  assign crit_idx  = adr_q[LINE_LSB-1:BYTE_BITS];
  assign accept    = (state == IDLE) && req_v;
  assign snoop_hit = st_v && ((state == FETCH) || (state == FILL)) &&
                     (st_adr[ADR_W-1:LINE_LSB] == adr_q[ADR_W-1:LINE_LSB]);

  rfphoenix_line_assembler #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .start     (asm_start),
    .start_idx (crit_idx),
    .beat_we   (beat_we),
    .beat_dat  (dat_i),
    .beat_idx  (beat_idx),
    .last_beat (last_beat),
    .complete  (line_done),
    .line      (line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      adr_q    <= '0;
      cach_q   <= 1'b0;
      sent_q   <= 1'b0;
      stale_q  <= 1'b0;
      tmo_cnt  <= '0;
      resp_v   <= 1'b0;
      resp_err <= 1'b0;
      resp_dat <= '0;
    end else begin
      state    <= state_nxt;
      resp_v   <= resp_v_nxt;
      resp_err <= resp_err_nxt;
      if (resp_ld) resp_dat <= resp_bus ? dat_i : dc_beat[crit_idx];
      if (accept) begin
        adr_q   <= req_adr;
        cach_q  <= req_acr[3];
        sent_q  <= 1'b0;
        stale_q <= 1'b0;
      end else begin
        if (resp_ld)   sent_q  <= 1'b1;
        if (snoop_hit) stale_q <= 1'b1;
      end
      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    resp_v_nxt   = 1'b0;
    resp_err_nxt = 1'b0;
    resp_ld      = 1'b0;
    resp_bus     = 1'b0;
    asm_start    = 1'b0;
    beat_we      = 1'b0;
    tmo_inc      = 1'b0;
    tmo_clr      = 1'b0;
    case (state)
      IDLE: if (req_v) state_nxt = LOOKUP;
      LOOKUP: begin
        if (cach_q && hit) begin
          resp_v_nxt = 1'b1;
          resp_ld    = 1'b1;
          state_nxt  = IDLE;
        end else begin
          asm_start = 1'b1;
          tmo_clr   = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // error beats an ack in the same cycle; a late error only abandons the fill
        if (err_i || (!ack_i && tmo_cnt == TMO_C)) begin
          resp_v_nxt   = !sent_q;
          resp_err_nxt = !sent_q;
          state_nxt    = IDLE;
        end else if (ack_i) begin
          beat_we = 1'b1;
          tmo_clr = 1'b1;
          if (!sent_q) begin
            resp_v_nxt = 1'b1;
            resp_ld    = 1'b1;
            resp_bus   = 1'b1;
          end
          if (!cach_q)        state_nxt = IDLE;
          else if (last_beat) state_nxt = FILL;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      FILL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_rdy = (state == IDLE);
  assign cyc_o   = (state == FETCH);
  assign stb_o   = (state == FETCH);
  assign adr_o   = {adr_q[ADR_W-1:LINE_LSB], beat_idx, {BYTE_BITS{1'b0}}};
  assign wr_dc   = (state == FILL) && line_done && !stale_q && !snoop_hit;
  assign wr_adr  = {adr_q[ADR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
  assign wr_line = line;

  logic unused_bits;
  assign unused_bits = ^{req_acr[2:0], st_adr[LINE_LSB-1:0], adr_q[BYTE_BITS-1:0]};

endmodule

// File: tb/tb_rfphoenix_dcache_rd.sv
// Directed bench for rfphoenix_dcache_rd: hit/uncached vector table plus refill,
// snoop, error, timeout and reset sequences.
module tb_rfphoenix_dcache_rd;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_v, req_rdy, hit, st_v;
  logic [31:0]   req_adr, st_adr, adr_o, wr_adr;
  logic [3:0]    req_acr;
  logic [511:0]  dc_dat, wr_line;
  logic          cyc_o, stb_o, ack_i, err_i, wr_dc, resp_v, resp_err;
  logic [127:0]  dat_i, resp_dat;

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int both_cnt = 0;

  rfphoenix_dcache_rd #(.ADR_W(32), .BEAT_W(128), .BEATS(4), .TMO(255)) dut (
    .clk(clk), .rst(rst), .req_v(req_v), .req_rdy(req_rdy), .req_adr(req_adr),
    .req_acr(req_acr), .hit(hit), .dc_dat(dc_dat), .st_v(st_v), .st_adr(st_adr),
    .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .ack_i(ack_i), .err_i(err_i),
    .dat_i(dat_i), .wr_dc(wr_dc), .wr_adr(wr_adr), .wr_line(wr_line),
    .resp_v(resp_v), .resp_dat(resp_dat), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_dc) wr_cnt++;
    if (wr_dc && resp_v) both_cnt++;
  end

  typedef struct {
    logic [31:0]  adr;
    logic [3:0]   acr;
    logic         hit;
    logic         bus;
    logic [31:0]  exp_adr;
    logic [127:0] exp_dat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] beat_val(input int s);
    logic [15:0] h;
    h = 16'hB000 + 16'(s);
    return {8{h}};
  endfunction

  task automatic start_req(input logic [31:0] adr, input logic [3:0] acr, input logic h);
    chk("rdy_idle", req_rdy, 1);
    req_v = 1; req_adr = adr; req_acr = acr; hit = h;
    tick();
    req_v = 0;
    chk("rdy_busy", req_rdy, 0);
    tick();
    hit = 0;
  endtask

  task automatic run_fill(input logic [31:0] adr, input int snoop_k, input int err_k,
                          input string tag);
    int crit, s, wr0;
    logic [511:0] exp_line;
    crit = int'(adr[5:4]);
    wr0 = wr_cnt;
    start_req(adr, 4'h8, 1'b0);
    for (int k = 0; k < 4; k++) begin
      s = (crit + k) % 4;
      chk({tag, "_cyc"}, cyc_o, 1);
      chk({tag, "_adr"}, adr_o, {adr[31:6], s[1:0], 4'h0});
      ack_i = 1; dat_i = beat_val(s);
      if (k == snoop_k) begin st_v = 1; st_adr = {adr[31:6], 6'h08}; end
      if (k == err_k) err_i = 1;
      tick();
      ack_i = 0; err_i = 0; st_v = 0;
      if (k == err_k) begin
        chk({tag, "_err_v"}, resp_v, (k == 0));
        chk({tag, "_err_e"}, resp_err, (k == 0));
        chk({tag, "_err_cyc"}, cyc_o, 0);
        chk({tag, "_err_rdy"}, req_rdy, 1);
        chk({tag, "_err_wr"}, wr_cnt, wr0);
        return;
      end
      if (k == 0) begin
        chk({tag, "_early_v"}, resp_v, 1);
        chk({tag, "_early_dat"}, resp_dat, beat_val(crit));
        chk({tag, "_early_err"}, resp_err, 0);
      end else begin
        chk({tag, "_resp_once"}, resp_v, 0);
      end
    end
    exp_line = {beat_val(3), beat_val(2), beat_val(1), beat_val(0)};
    chk({tag, "_wr_dc"}, wr_dc, (snoop_k < 0));
    chk({tag, "_wr_adr"}, wr_adr, {adr[31:6], 6'h00});
    chk({tag, "_wr_line"}, wr_line, exp_line);
    chk({tag, "_fill_cyc"}, cyc_o, 0);
    tick();
    chk({tag, "_wr_pulse"}, wr_dc, 0);
    chk({tag, "_wr_cnt"}, wr_cnt, wr0 + ((snoop_k < 0) ? 1 : 0));
  endtask

  initial begin
    int cyc_cnt, wr0;
    rst = 1; req_v = 0; req_adr = '0; req_acr = '0; hit = 0; st_v = 0; st_adr = '0;
    ack_i = 0; err_i = 0; dat_i = '0;
    dc_dat = {{16{8'hA5}}, {16{8'hC3}}, {16{8'h3C}}, {16{8'h5A}}};

    vecs[0] = '{32'h0000_1030, 4'h8, 1'b1, 1'b0, 32'h0, {16{8'hA5}}};
    vecs[1] = '{32'h0000_1000, 4'h8, 1'b1, 1'b0, 32'h0, {16{8'h5A}}};
    vecs[2] = '{32'h0000_1014, 4'h8, 1'b1, 1'b0, 32'h0, {16{8'h3C}}};
    vecs[3] = '{32'h0000_103C, 4'h9, 1'b1, 1'b0, 32'h0, {16{8'hA5}}};
    vecs[4] = '{32'h0000_3000, 4'h0, 1'b0, 1'b1, 32'h0000_3000, {4{32'hDEAD_0001}}};
    vecs[5] = '{32'h0000_3028, 4'h0, 1'b1, 1'b1, 32'h0000_3020, {4{32'hDEAD_0002}}};
    vecs[6] = '{32'h0000_3034, 4'h7, 1'b1, 1'b1, 32'h0000_3030, {4{32'hDEAD_0003}}};

    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_rdy", req_rdy, 1);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_stb", stb_o, 0);
    chk("rst_resp_v", resp_v, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_wr_dc", wr_dc, 0);
    chk("rst_adr_o", adr_o, 0);
    chk("rst_wr_line", wr_line, 0);
    chk("rst_resp_dat", resp_dat, 0);

    wr0 = wr_cnt;
    for (int i = 0; i < 7; i++) begin
      start_req(vecs[i].adr, vecs[i].acr, vecs[i].hit);
      if (vecs[i].bus) begin
        chk("nc_cyc", cyc_o, 1);
        chk("nc_stb", stb_o, 1);
        chk("nc_adr", adr_o, vecs[i].exp_adr);
        chk("nc_no_early", resp_v, 0);
        ack_i = 1; dat_i = vecs[i].exp_dat;
        tick();
        ack_i = 0;
        chk("nc_cyc_drop", cyc_o, 0);
      end else begin
        chk("hit_no_cyc", cyc_o, 0);
      end
      chk("vec_resp_v", resp_v, 1);
      chk("vec_resp_dat", resp_dat, vecs[i].exp_dat);
      chk("vec_resp_err", resp_err, 0);
      tick();
      chk("vec_resp_pulse", resp_v, 0);
    end
    chk("vec_no_wr", wr_cnt, wr0);

    run_fill(32'h0000_2020, 1, -1, "snoop");
    run_fill(32'h0000_2020, -1, -1, "fill");
    run_fill(32'h0000_2020, -1, 2, "err_late");
    run_fill(32'h0000_2000, -1, 0, "err_early");

    start_req(32'h0000_3000, 4'h0, 1'b0);
    cyc_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (resp_v) break;
      if (cyc_o) cyc_cnt++;
      tick();
    end
    chk("tmo_resp_v", resp_v, 1);
    chk("tmo_resp_err", resp_err, 1);
    chk("tmo_cyc", cyc_o, 0);
    chk("tmo_cycles", cyc_cnt, 256);
    tick();

    wr0 = wr_cnt;
    start_req(32'h0000_2020, 4'h8, 1'b0);
    ack_i = 1; dat_i = beat_val(2);
    tick();
    ack_i = 0; rst = 1;
    tick();
    rst = 0;
    chk("rstf_cyc", cyc_o, 0);
    chk("rstf_rdy", req_rdy, 1);
    chk("rstf_resp_v", resp_v, 0);
    chk("rstf_wr_dc", wr_dc, 0);
    chk("rstf_adr_o", adr_o, 0);
    tick();
    chk("rstf_wr_cnt", wr_cnt, wr0);

    chk("resp_wr_overlap", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rfphoenix_dcache_rd.md
Name: rfphoenix_dcache_rd

Overview:
Data-cache read/refill engine: the load-side counterpart to the store path that raises the dcache write strobe.
- Accepts a load request and checks the tag hit, then returns the data.
- On a cacheable miss it fetches a full line over the memory bus, assembles the beats and pulses wr_dc with the line so the cache is updated.
- Non-cacheable loads bypass the cache and use a single-beat bus read.
- Sits between the memory-stage load unit and the bus interface unit.

Parameters:
ADR_W, 32, physical address width
BEAT_W, 128, bus data width per beat
BEATS, 4, beats per cache line (power of 2, 2..8)
TMO, 255, bus-ack timeout in cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_v  in  1  load request valid
req_rdy  out  1  engine idle, request accepted this cycle
req_adr  in  ADR_W  load address
req_acr  in  4  access rights; bit 3 = cacheable
hit  in  1  tag hit for req_adr, valid in LOOKUP
dc_dat  in  BEAT_W*BEATS  cache line read data, valid in LOOKUP
st_v  in  1  store committing this cycle (snoop)
st_adr  in  ADR_W  store address
cyc_o  out  1  bus cycle
stb_o  out  1  bus strobe
adr_o  out  ADR_W  bus address, beat aligned
ack_i  in  1  bus beat ack
err_i  in  1  bus error
dat_i  in  BEAT_W  bus read data
wr_dc  out  1  one-cycle cache line write strobe
wr_adr  out  ADR_W  line-aligned address for wr_dc
wr_line  out  BEAT_W*BEATS  line data for wr_dc
resp_v  out  1  one-cycle load response
resp_dat  out  BEAT_W  beat containing req_adr
resp_err  out  1  bus error or timeout on this load

Behaviour:
- Reset:
  - state=IDLE; req_rdy=1.
  - cyc_o, stb_o, wr_dc, resp_v and resp_err = 0.
  - adr_o, wr_adr, wr_line, resp_dat = 0; beat counter = 0; timeout counter = 0.
  - Reset mid-fill drops the bus cycle next edge; no wr_dc is issued.
- IDLE:
  - req_rdy=1.
  - On req_v, latch adr/acr and go to LOOKUP.
- LOOKUP (1 cycle):
  - If hit and acr[3]: resp_v=1 next cycle with resp_dat = dc_dat beat selected by the adr beat-index bits; go to IDLE.
  - If acr[3] and no hit: go to FETCH with beat counter = critical beat index (adr beat bits).
  - If !acr[3]: go to FETCH as a single-beat read.
  - Hit latency is 2 cycles from the accepting edge.
- FETCH:
  - cyc_o=stb_o=1; adr_o = {line addr, beat counter, zero byte bits}.
  - On ack_i: store dat_i into line slot[beat counter]; increment beat counter mod BEATS (wrap-around; critical beat first); count beats received.
  - The first acked beat, when it is the critical beat, asserts resp_v with resp_dat=dat_i on the following cycle (early restart).
  - stb_o stays high between beats; cyc_o drops after the last ack.
  - Cacheable case: BEATS acks, then go to FILL.
  - Non-cacheable case: 1 ack, then go to IDLE.
- FILL (1 cycle):
  - wr_dc=1, wr_adr = line-aligned adr, wr_line = assembled line; go to IDLE.
  - If a snoop marked the line stale, wr_dc is not pulsed.
- Snoop: st_v with st_adr in the same line during FETCH or FILL sets a stale flag.
  - The stale flag suppresses wr_dc.
  - The load response is still returned; the store path owns coherence.
- Error:
  - err_i, or the timeout counter reaching TMO without an ack, drops cyc_o/stb_o.
  - resp_v=1 and resp_err=1 are asserted for one cycle, unless a response was already sent for this load (early restart). In that case the error is not reported and only the fill is abandoned.
  - No wr_dc; go to IDLE.
  - The timeout counter clears on every ack.
- Simultaneous events:
  - ack_i and err_i in the same cycle: err wins and the beat is discarded.
  - req_v while not IDLE is ignored (req_rdy=0).
  - resp_v and wr_dc are never both high in the same cycle.

Decomposition:
- Package rfPhoenixPkg gains:
  - the dcache_rd_state_t enum (IDLE, LOOKUP, FETCH, FILL);
  - constants DC_LINE_BYTES and DC_BEAT_BYTES.
- Optional sub-module rfphoenix_line_assembler: beat-slot register file with wrap counter, beat count and a complete flag.

Test Plan:
- Hit: req_adr=0x1030, acr=4'h8, hit=1, dc_dat slot3=A5.. -> resp_v two cycles after accept with resp_dat=slot3; no cyc_o.
- Miss fill with wrap: req_adr=0x2020 (beat 2), acr=4'h8, hit=0, acks every cycle -> adr_o sequence 0x2020, 0x2030, 0x2000, 0x2010. resp_v after the first ack; a single wr_dc with wr_adr=0x2000 and line slots in order.
- Non-cacheable: acr=4'h0, address 0x3000 -> one bus beat, resp_v with dat_i, wr_dc never asserted.
- Snoop: st_v with st_adr=0x2008 during the second beat of a fill -> response delivered, wr_dc stays 0.
- Error/timeout: err_i on beat 2 with an early response already sent -> no resp_err, no wr_dc. With ack_i never asserted and TMO=255 -> resp_err at cycle 256, cyc_o low.
- Reset during FETCH -> next cycle cyc_o=0, req_rdy=1, no wr_dc or resp_v.
